fpga_mmio_ctrl: RTL and testbench
=================================

// Module: fpga_mmio_ctrl
// PURPOSE
//  Parametrised F2C memory-mapped I/O slave for the FPGA board: N seven-segment digits, LED bank, switches, buttons.
//  Adds 2-flop input synchronisers, per-button debounce, sticky W1C event register, interrupt output,
//  and a hex-decode display mode. Sits on the F2C request/response path, replacing the fixed-width board CR block.
// PARAMETERS
//  NUM_SEG7      6      number of 7-seg digits (1..8)
//  LED_W         10     LED bank width (1..32)
//  SW_W          10     switch width (1..32)
//  NUM_BTN       2      button count (1..8)
//  DEBOUNCE_CYC  50000  consecutive stable cycles before a button level is accepted (>=1)
// PORTS
//  CLK_50               in   1          clock
//  RstQnnnH             in   1          asynchronous, active-low reset
//  F2C_ReqValidQ502H    in   1          request valid
//  F2C_ReqOpcodeQ502H   in   t_opcode   RD or WR; other opcodes ignored (no response)
//  F2C_ReqAddressQ502H  in   32         byte address; offset = [19:0]
//  F2C_ReqDataQ502H     in   32         write data
//  F2C_RspValidQ500H    out  1          response valid
//  F2C_RspOpcodeQ500H   out  t_opcode   always RD_RSP
//  F2C_RspAddressQ500H  out  32         echo of request address
//  F2C_RspDataQ500H     out  32         read data; 0 for WR and unmapped
//  Button               in   NUM_BTN    raw pins, active-low (0 = pressed)
//  Switch               in   SW_W       raw switch pins
//  SEG7                 out  7*NUM_SEG7 digit i = [7i+6:7i], active-low segments {g..a}
//  LED                  out  LED_W      LED drive
//  IrqQ                 out  1          |(EVENT & IRQ_EN), registered
// BEHAVIOUR
//  Register map (offset[19:0]; 4-byte aligned; offset[1:0] ignored):
//   0x000+4i SEG7_RAW[i] RW [6:0], i<NUM_SEG7; reset 7'h7F (blank)
//   0x040 LED RW [LED_W-1:0], reset 0      0x044 SWITCH RO synced switches
//   0x048 BTN RO debounced pressed level (1 = pressed)
//   0x04C EVENT W1C: [NUM_BTN-1:0] button press, [8] switch change; reset 0
//   0x050 CTRL RW: [0] HEX_MODE, [1] IRQ_EN; reset 0
//   0x054 HEX_VAL RW [4*NUM_SEG7-1:0], reset 0. Unmapped: reads 0, writes dropped; RO writes dropped.
//  Pipeline: req sampled into Q503 flops; decode + register write in Q503; rsp flops Q504 then Q500.
//   Request at input cycle N -> RspValid=1 at output cycle N+3, one response per RD/WR, back-to-back fully supported.
//   RD data reflects all writes accepted in earlier cycles. Register write visible on SEG7/LED pins at cycle N+2.
//  Display: HEX_MODE=0 -> SEG7 digit i = SEG7_RAW[i]; HEX_MODE=1 -> digit i = ~decode(HEX_VAL[4i+3:4i]),
//   standard 0-F glyphs (e.g. 0 -> 7'h40, 8 -> 7'h00, F -> 7'h0E). SEG7 and LED are registered outputs.
//  Inputs: Button and Switch pass 2-flop synchronisers (reset value 1 for buttons, 0 for switches).
//  Debounce per button: counter clears when synced == stable; else increments; at DEBOUNCE_CYC stable <= synced,
//   counter clears. Stable reset = released. Stable released->pressed sets EVENT[b]; release sets nothing.
//  Switch change: synced Switch differs from previous-cycle synced value -> EVENT[8] set.
//  W1C: write of 1 clears bit; same-cycle set and clear -> set wins. Writes of 0 have no effect.
//  IrqQ: registered, reset 0; follows EVENT/IRQ_EN with one cycle latency.
//  Reset (async assert, sync release use): all outputs 0 except SEG7 = all 1s (blank); debounce counters 0;
//   in-flight requests dropped, no response produced for them.
//  Counter width $clog2(DEBOUNCE_CYC+1); never wraps (saturates by clear at threshold).
// TESTING
//  1. WR 0x040 data 0x3FF, then RD 0x040 -> LED=10'h3FF at N+2; rsp valid at N+3 with data 0x3FF, opcode RD_RSP.
//  2. WR CTRL=1, HEX_VAL=0x0123AF -> SEG7 digits 0..5 = 0x0E,0x08,0x30,0x24,0x79,0x40; CTRL=0 restores raw 7'h7F.
//  3. DEBOUNCE_CYC=8: Button[0] low 5 cycles then high -> no EVENT; low 12 cycles -> BTN=1, EVENT[0]=1.
//  4. EVENT[0]=1, IRQ_EN=1 -> IrqQ=1; WR EVENT 0x1 in same cycle as new press -> EVENT[0] stays 1; later W1C -> IrqQ 0.
//  5. Back-to-back RD to 0x044, 0x0FC, WR 0x048 -> three consecutive rsps: switch value, 0, 0; BTN unchanged.
//  6. Assert RstQnnnH=0 mid-stream with 2 requests in flight -> no responses, LED=0, SEG7 all 1s, EVENT=0.

Source files
------------

// File: rtl/fpga_mmio_ctrl_if.sv
// rtl/fpga_mmio_ctrl_if.sv - F2C request/response bus and opcode type for the board MMIO slave
package fpga_mmio_pkg;
  typedef enum logic [1:0] {
    OP_RD     = 2'd0,
    OP_WR     = 2'd1,
    OP_RD_RSP = 2'd2,
    OP_WR_RSP = 2'd3
  } t_opcode;
endpackage

interface fpga_mmio_ctrl_if;
  import fpga_mmio_pkg::*;

  logic        F2C_ReqValidQ502H;
  t_opcode     F2C_ReqOpcodeQ502H;
  logic [31:0] F2C_ReqAddressQ502H;
  logic [31:0] F2C_ReqDataQ502H;
  logic        F2C_RspValidQ500H;
  t_opcode     F2C_RspOpcodeQ500H;
  logic [31:0] F2C_RspAddressQ500H;
  logic [31:0] F2C_RspDataQ500H;

  modport master (
    output F2C_ReqValidQ502H, F2C_ReqOpcodeQ502H, F2C_ReqAddressQ502H, F2C_ReqDataQ502H,
    input  F2C_RspValidQ500H, F2C_RspOpcodeQ500H, F2C_RspAddressQ500H, F2C_RspDataQ500H
  );

  modport slave (
    input  F2C_ReqValidQ502H, F2C_ReqOpcodeQ502H, F2C_ReqAddressQ502H, F2C_ReqDataQ502H,
    output F2C_RspValidQ500H, F2C_RspOpcodeQ500H, F2C_RspAddressQ500H, F2C_RspDataQ500H
  );
endinterface

// File: rtl/fpga_mmio_ctrl.sv
// rtl/fpga_mmio_ctrl.sv - F2C MMIO slave: 7-seg digits, LEDs, synced switches, debounced buttons, W1C events, IRQ
module fpga_mmio_ctrl
  import fpga_mmio_pkg::*;
#(
  parameter int NUM_SEG7     = 6,
  parameter int LED_W        = 10,
  parameter int SW_W         = 10,
  parameter int NUM_BTN      = 2,
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic                  CLK_50,
  input  logic                  RstQnnnH,
  fpga_mmio_ctrl_if.slave       f2c,
  input  logic [NUM_BTN-1:0]    Button,
  input  logic [SW_W-1:0]       Switch,
  output logic [7*NUM_SEG7-1:0] SEG7,
  output logic [LED_W-1:0]      LED,
  output logic                  IrqQ
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int HEX_W = 4 * NUM_SEG7;

  // Active-low {g..a} glyphs for hex digits 0-F
  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'h40;  4'h1: g = 7'h79;  4'h2: g = 7'h24;  4'h3: g = 7'h30;
      4'h4: g = 7'h19;  4'h5: g = 7'h12;  4'h6: g = 7'h02;  4'h7: g = 7'h78;
      4'h8: g = 7'h00;  4'h9: g = 7'h10;  4'hA: g = 7'h08;  4'hB: g = 7'h03;
      4'hC: g = 7'h46;  4'hD: g = 7'h21;  4'hE: g = 7'h06;  default: g = 7'h0E;
    endcase
    return g;
  endfunction

  logic                         req_vld_q, req_wr_q;
  logic [31:0]                  req_addr_q, req_data_q;
  logic                         rsp1_vld_q;
  logic [31:0]                  rsp1_addr_q, rsp1_data_q;
  logic                         rsp_vld_q;
  t_opcode                      rsp_op_q;
  logic [31:0]                  rsp_addr_q, rsp_data_q;

  logic [NUM_SEG7-1:0][6:0]     seg_raw_q, seg_raw_d;
  logic [LED_W-1:0]             led_q, led_d;
  logic [1:0]                   ctrl_q, ctrl_d;
  logic [HEX_W-1:0]             hex_q, hex_d;
  logic [8:0]                   event_q, event_d;
  logic [7*NUM_SEG7-1:0]        seg7_q, seg7_d;
  logic                         irq_q;

  logic [NUM_BTN-1:0]           btn_s1_q, btn_s2_q, stable_q, stable_d;
  logic [NUM_BTN-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [SW_W-1:0]              sw_s1_q, sw_s2_q, sw_prev_q;

  logic [17:0]                  word;
  logic                         is_wr;
  logic [31:0]                  rd_data;
  logic [8:0]                   evt_set, evt_clr;
  logic                         unused_data;

  assign unused_data = ^req_data_q;

  // Register decode; reads see state before this cycle's write
  always_comb begin
    word      = req_addr_q[19:2];
    is_wr     = req_vld_q && req_wr_q;
    seg_raw_d = seg_raw_q;
    led_d     = led_q;
    ctrl_d    = ctrl_q;
    hex_d     = hex_q;
    evt_clr   = '0;
    rd_data   = '0;
    for (int i = 0; i < NUM_SEG7; i++) begin
      if (word == 18'(i)) begin
        rd_data = {25'b0, seg_raw_q[i]};
        if (is_wr) seg_raw_d[i] = req_data_q[6:0];
      end
    end
    case (word)
      18'h10: begin
        rd_data = 32'(led_q);
        if (is_wr) led_d = req_data_q[LED_W-1:0];
      end
      18'h11: rd_data = 32'(sw_s2_q);
      18'h12: rd_data = 32'(stable_q);
      18'h13: begin
        rd_data = 32'(event_q);
        if (is_wr) evt_clr = req_data_q[8:0];
      end
      18'h14: begin
        rd_data = 32'(ctrl_q);
        if (is_wr) ctrl_d = req_data_q[1:0];
      end
      18'h15: begin
        rd_data = 32'(hex_q);
        if (is_wr) hex_d = req_data_q[HEX_W-1:0];
      end
      default: ;
    endcase
  end

  // Debounce in pressed polarity; a new press outranks a same-cycle W1C
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    evt_set  = '0;
    for (int b = 0; b < NUM_BTN; b++) begin
      if (~btn_s2_q[b] == stable_q[b]) begin
        cnt_d[b] = '0;
      end else if (cnt_q[b] == CNT_W'(DEBOUNCE_CYC - 1)) begin
        stable_d[b] = ~btn_s2_q[b];
        cnt_d[b]    = '0;
      end else begin
        cnt_d[b] = cnt_q[b] + CNT_W'(1);
      end
      evt_set[b] = stable_d[b] & ~stable_q[b];
    end
    evt_set[8] = (sw_s2_q != sw_prev_q);
    event_d    = (event_q & ~evt_clr) | evt_set;
  end

  // Built from next-state so a write reaches the pins one cycle after decode
  always_comb begin
    seg7_d = '1;
    for (int i = 0; i < NUM_SEG7; i++) begin
      seg7_d[7*i +: 7] = ctrl_d[0] ? hex_glyph(hex_d[4*i +: 4]) : seg_raw_d[i];
    end
  end

  always_ff @(posedge CLK_50 or negedge RstQnnnH) begin
    if (!RstQnnnH) begin
      req_vld_q   <= 1'b0;
      req_wr_q    <= 1'b0;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      rsp1_vld_q  <= 1'b0;
      rsp1_addr_q <= '0;
      rsp1_data_q <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_op_q    <= OP_RD;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
    end else begin
      req_vld_q   <= f2c.F2C_ReqValidQ502H &&
                     (f2c.F2C_ReqOpcodeQ502H == OP_RD || f2c.F2C_ReqOpcodeQ502H == OP_WR);
      req_wr_q    <= (f2c.F2C_ReqOpcodeQ502H == OP_WR);
      req_addr_q  <= f2c.F2C_ReqAddressQ502H;
      req_data_q  <= f2c.F2C_ReqDataQ502H;
      rsp1_vld_q  <= req_vld_q;
      rsp1_addr_q <= req_addr_q;
      rsp1_data_q <= req_wr_q ? 32'h0 : rd_data;
      rsp_vld_q   <= rsp1_vld_q;
      rsp_addr_q  <= rsp1_addr_q;
      rsp_data_q  <= rsp1_data_q;
      if (rsp1_vld_q) rsp_op_q <= OP_RD_RSP;
    end
  end

  always_ff @(posedge CLK_50 or negedge RstQnnnH) begin
    if (!RstQnnnH) begin
      seg_raw_q <= '1;
      led_q     <= '0;
      ctrl_q    <= '0;
      hex_q     <= '0;
      event_q   <= '0;
      seg7_q    <= '1;
      irq_q     <= 1'b0;
      btn_s1_q  <= '1;
      btn_s2_q  <= '1;
      stable_q  <= '0;
      cnt_q     <= '0;
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      sw_prev_q <= '0;
    end else begin
      seg_raw_q <= seg_raw_d;
      led_q     <= led_d;
      ctrl_q    <= ctrl_d;
      hex_q     <= hex_d;
      event_q   <= event_d;
      seg7_q    <= seg7_d;
      irq_q     <= |(event_q & {9{ctrl_q[1]}});
      btn_s1_q  <= Button;
      btn_s2_q  <= btn_s1_q;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      sw_s1_q   <= Switch;
      sw_s2_q   <= sw_s1_q;
      sw_prev_q <= sw_s2_q;
    end
  end

  assign f2c.F2C_RspValidQ500H   = rsp_vld_q;
  assign f2c.F2C_RspOpcodeQ500H  = rsp_op_q;
  assign f2c.F2C_RspAddressQ500H = rsp_addr_q;
  assign f2c.F2C_RspDataQ500H    = rsp_data_q;
  assign SEG7 = seg7_q;
  assign LED  = led_q;
  assign IrqQ = irq_q;
endmodule

// File: tb/tb_fpga_mmio_ctrl.sv
// tb/tb_fpga_mmio_ctrl.sv - scoreboard bench for fpga_mmio_ctrl
module tb_fpga_mmio_ctrl;
  import fpga_mmio_pkg::*;

  localparam int NUM_SEG7 = 6;
  localparam int LED_W    = 10;
  localparam int SW_W     = 10;
  localparam int NUM_BTN  = 2;
  localparam int DEB      = 8;

  logic                  clk   = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NUM_BTN-1:0]    button = '1;
  logic [SW_W-1:0]       sw = 10'h2A5;
  logic [7*NUM_SEG7-1:0] seg7;
  logic [LED_W-1:0]      led;
  logic                  irq;
  logic [7*NUM_SEG7-1:0] blank = '1;

  fpga_mmio_ctrl_if bus();

  fpga_mmio_ctrl #(
    .NUM_SEG7(NUM_SEG7), .LED_W(LED_W), .SW_W(SW_W), .NUM_BTN(NUM_BTN), .DEBOUNCE_CYC(DEB)
  ) dut (
    .CLK_50(clk), .RstQnnnH(rst_n), .f2c(bus), .Button(button), .Switch(sw),
    .SEG7(seg7), .LED(led), .IrqQ(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.F2C_RspValidQ500H) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rsp_unexpected: got response addr 0x%0h data 0x%0h expected none",
                 bus.F2C_RspAddressQ500H, bus.F2C_RspDataQ500H);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_addr", bus.F2C_RspAddressQ500H, mon_e.addr);
        chk("rsp_data", bus.F2C_RspDataQ500H, mon_e.data);
        chk("rsp_opcode", bus.F2C_RspOpcodeQ500H, OP_RD_RSP);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic req(input t_opcode op, input logic [31:0] addr, input logic [31:0] data,
                     input logic [31:0] exp, input bit push);
    if (push) sb.push_back('{addr, (op == OP_WR) ? 32'h0 : exp});
    bus.F2C_ReqValidQ502H   = 1'b1;
    bus.F2C_ReqOpcodeQ502H  = op;
    bus.F2C_ReqAddressQ502H = addr;
    bus.F2C_ReqDataQ502H    = data;
    @(posedge clk);
    #1;
    bus.F2C_ReqValidQ502H   = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    req(OP_WR, addr, data, 32'h0, 1'b1);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
    req(OP_RD, addr, 32'h0, exp, 1'b1);
  endtask

  initial begin
    bus.F2C_ReqValidQ502H   = 1'b0;
    bus.F2C_ReqOpcodeQ502H  = OP_RD;
    bus.F2C_ReqAddressQ502H = '0;
    bus.F2C_ReqDataQ502H    = '0;
    tick(3);
    rst_n = 1'b1;

    chk("rst_led", led, 0);
    chk("rst_seg7", seg7, blank);
    chk("rst_irq", irq, 0);
    chk("rst_rsp_valid", bus.F2C_RspValidQ500H, 0);

    // LED write latency and read-back, address bits outside the offset ignored
    wr(32'h40, 32'h3FF);
    chk("led_at_n1", led, 0);
    tick(1);
    chk("led_at_n2", led, 10'h3FF);
    tick(1);
    chk("rsp_valid_at_n3", bus.F2C_RspValidQ500H, 1);
    rd(32'h40, 32'h3FF);
    rd(32'h43, 32'h3FF);
    rd(32'hABC0_0040, 32'h3FF);
    tick(4);

    // Hex display mode versus raw segments
    wr(32'h08, 32'h12);
    wr(32'h50, 32'h1);
    wr(32'h54, 32'h0012_3AF);
    tick(3);
    chk("seg7_hex", seg7, {7'h40, 7'h79, 7'h24, 7'h30, 7'h08, 7'h0E});
    wr(32'h50, 32'h0);
    tick(2);
    chk("seg7_raw", seg7, {7'h7F, 7'h7F, 7'h7F, 7'h12, 7'h7F, 7'h7F});
    rd(32'h54, 32'h0012_3AF);
    rd(32'h08, 32'h12);
    rd(32'h18, 32'h0);
    rd(32'h4C, 32'h100);
    wr(32'h4C, 32'h100);
    tick(2);
    rd(32'h4C, 32'h0);

    // Debounce: short glitch ignored, long press accepted, release sets no event
    button[0] = 1'b0;
    tick(5);
    button[0] = 1'b1;
    tick(12);
    rd(32'h4C, 32'h0);
    rd(32'h48, 32'h0);
    button[0] = 1'b0;
    tick(12);
    rd(32'h48, 32'h1);
    rd(32'h4C, 32'h1);
    button[0] = 1'b1;
    tick(15);
    rd(32'h48, 32'h0);
    rd(32'h4C, 32'h1);

    // IRQ and set-wins-over-clear
    wr(32'h50, 32'h2);
    tick(2);
    chk("irq_on", irq, 1);
    wr(32'h4C, 32'h1);
    tick(2);
    chk("irq_cleared", irq, 0);
    button[0] = 1'b0;
    tick(8);
    wr(32'h4C, 32'h1);
    tick(3);
    chk("irq_set_wins", irq, 1);
    rd(32'h4C, 32'h1);
    wr(32'h4C, 32'h1);
    tick(3);
    chk("irq_final_clear", irq, 0);

    // Back-to-back: switch, unmapped, RO write; then BTN unchanged
    rd(32'h44, 32'h2A5);
    rd(32'h0FC, 32'h0);
    wr(32'h48, 32'h0);
    tick(2);
    rd(32'h48, 32'h1);

    // Non RD/WR opcodes produce nothing and change nothing
    req(OP_RD_RSP, 32'h40, 32'h0, 32'h0, 1'b0);
    req(OP_WR_RSP, 32'h40, 32'h0, 32'h0, 1'b0);
    tick(3);
    rd(32'h40, 32'h3FF);
    tick(4);
    chk("sb_drained", sb.size(), 0);

    // Reset with two requests in flight
    button[0] = 1'b1;
    sw = 10'h15A;
    tick(4);
    sw = 10'h000;
    tick(15);
    req(OP_WR, 32'h40, 32'h1, 32'h0, 1'b0);
    req(OP_RD, 32'h4C, 32'h0, 32'h0, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("rst_mid_led", led, 0);
    chk("rst_mid_seg7", seg7, blank);
    tick(1);
    rst_n = 1'b1;
    tick(5);
    chk("post_rst_led", led, 0);
    chk("post_rst_seg7", seg7, blank);
    chk("post_rst_irq", irq, 0);
    rd(32'h4C, 32'h0);
    rd(32'h48, 32'h0);
    rd(32'h40, 32'h0);
    tick(6);
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
